// File: rtl/sharp_frame_buffer.sv
// Frame store and dirty-line flush sequencer for the 144x168 Sharp memory LCD.
// Define SHARP_FB_VCOM_EN to build the VCOM_DIV toggle counter; otherwise vcom is held at 0.
module sharp_frame_buffer #(
  parameter int LINE_PIXELS = 144,
  parameter int NUM_LINES   = 168,
  parameter int VCOM_DIV    = 6000000
) (
  input  logic                   Clk_12MHz,
  input  logic                   Rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_line,
  input  logic [7:0]             wr_col,
  input  logic                   wr_pixel,
  input  logic                   refresh,
  input  logic                   clear_all,
  output logic                   line_valid,
  input  logic                   line_ready,
  output logic [7:0]             line_addr,
  output logic [LINE_PIXELS-1:0] line_data,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   vcom
);
  localparam logic [7:0] LAST = 8'(NUM_LINES);
  localparam logic [7:0] COLS = 8'(LINE_PIXELS);

  typedef enum logic [1:0] {IDLE, SCAN, PRESENT, CLEAR} state_t;

  typedef struct packed {
    logic       en;
    logic [7:0] line;
    logic [7:0] col;
    logic       pixel;
  } wr_req_t;

  state_t                 state;
  logic [7:0]             idx;
  logic [NUM_LINES:1]     dirty;
  logic [LINE_PIXELS-1:0] fb [1:NUM_LINES];
  wr_req_t                req;
  logic                   wr_ok, hs, last;

  assign req   = '{en: wr_en, line: wr_line, col: wr_col, pixel: wr_pixel};
  assign wr_ok = req.en && (state != CLEAR) && (req.line != 8'd0) &&
                 (req.line <= LAST) && (req.col < COLS);
  assign hs    = (state == PRESENT) && line_valid && line_ready;
  assign last  = (idx == LAST);

  // Combinational so the pulse lands in the final SCAN/CLEAR cycle or the last handshake.
  assign frame_done = last && (((state == SCAN) && !dirty[idx]) || hs || (state == CLEAR));

  // Pixel array is intentionally not reset.
  always_ff @(posedge Clk_12MHz) begin
    if (state == CLEAR)
      fb[idx] <= '1;
    else if (wr_ok)
      fb[req.line][req.col] <= req.pixel;
  end

  always_ff @(posedge Clk_12MHz or posedge Rst) begin
    if (Rst) begin
      state      <= IDLE;
      idx        <= 8'd1;
      dirty      <= '0;
      line_valid <= 1'b0;
      line_addr  <= 8'd0;
      line_data  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_all) begin
            state <= CLEAR;
            idx   <= 8'd1;
            busy  <= 1'b1;
          end else if (refresh) begin
            state <= SCAN;
            idx   <= 8'd1;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (dirty[idx]) begin
            line_data  <= fb[idx];
            line_addr  <= idx;
            line_valid <= 1'b1;
            state      <= PRESENT;
          end else if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            idx <= idx + 8'd1;
          end
        end
        PRESENT: begin
          if (hs) begin
            line_valid <= 1'b0;
            dirty[idx] <= 1'b0;
            if (last) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              idx   <= idx + 8'd1;
              state <= SCAN;
            end
          end
        end
        CLEAR: begin
          dirty[idx] <= 1'b1;
          if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            idx <= idx + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
      // A host write outranks the handshake clear of the same line.
      if (wr_ok) dirty[req.line] <= 1'b1;
    end
  end

`ifdef SHARP_FB_VCOM_EN
  logic [31:0] vcnt;

  always_ff @(posedge Clk_12MHz or posedge Rst) begin
    if (Rst) begin
      vcnt <= 32'd0;
      vcom <= 1'b0;
    end else if (vcnt == 32'(VCOM_DIV - 1)) begin
      vcnt <= 32'd0;
      vcom <= ~vcom;
    end else begin
      vcnt <= vcnt + 32'd1;
    end
  end
`else
  logic unused_div;
  assign unused_div = ^32'(VCOM_DIV);
  assign vcom       = 1'b0;
`endif
endmodule

// File: tb/tb_sharp_frame_buffer.sv
// Directed bench for sharp_frame_buffer: write vector table plus stall, race and reset sequences.
module tb_sharp_frame_buffer;
  localparam int LP = 144;
  localparam int NL = 168;
`ifdef SHARP_FB_VCOM_EN
  localparam int VD = 4;
`else
  localparam int VD = 6000000;
`endif

  logic clk = 0, rst = 1, wr_en = 0, wr_pixel = 0, refresh = 0, clear_all = 0, line_ready = 0;
  logic [7:0] wr_line = 0, wr_col = 0;
  logic line_valid, busy, frame_done, vcom;
  logic [7:0] line_addr;
  logic [LP-1:0] line_data;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  sharp_frame_buffer #(.LINE_PIXELS(LP), .NUM_LINES(NL), .VCOM_DIV(VD)) dut (
    .Clk_12MHz(clk), .Rst(rst), .wr_en(wr_en), .wr_line(wr_line), .wr_col(wr_col),
    .wr_pixel(wr_pixel), .refresh(refresh), .clear_all(clear_all), .line_valid(line_valid),
    .line_ready(line_ready), .line_addr(line_addr), .line_data(line_data), .busy(busy),
    .frame_done(frame_done), .vcom(vcom)
  );

  logic [7:0]    got_addr[$];
  logic [LP-1:0] got_data[$];
  int   done_cyc, done_cnt;
  logic busy_first, busy_after;

  typedef struct {
    int l; int c; bit p; bit hit; int addr; int zcol;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [LP-1:0] ones_but(input int z);
    logic [LP-1:0] d = '1;
    if (z >= 0 && z < LP) d[z] = 1'b0;
    return d;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int l, input int c, input bit p);
    wr_en = 1; wr_line = 8'(l); wr_col = 8'(c); wr_pixel = p;
    cyc();
    wr_en = 0;
  endtask

  // Pulses refresh or clear_all in cycle N; c counts cycles N+1.. ; poke re-issues both commands.
  task automatic run_op(input bit clr, input int poke);
    got_addr.delete(); got_data.delete();
    done_cyc = -1; done_cnt = 0;
    refresh = !clr; clear_all = clr;
    cyc();
    refresh = 0; clear_all = 0;
    busy_first = busy;
    for (int c = 1; c <= 1000; c++) begin
      if (c == poke) begin refresh = 1; clear_all = 1; end
      @(negedge clk);
      if (line_valid && line_ready) begin
        got_addr.push_back(line_addr);
        got_data.push_back(line_data);
      end
      if (frame_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      cyc();
      refresh = 0; clear_all = 0;
      if (done_cyc == c) busy_after = busy;
      if (done_cyc > 0 && c >= done_cyc + 4) break;
    end
    if (done_cyc < 0) fail_now("op_timeout");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, bad;
    vt[0] = '{50,   0, 0, 1,  50,   0};
    vt[1] = '{50, 143, 0, 1,  50, 143};
    vt[2] = '{ 1,   5, 0, 1,   1,   5};
    vt[3] = '{168, 77, 0, 1, 168,  77};
    vt[4] = '{ 0,   3, 0, 0,   0,  -1};
    vt[5] = '{169,  3, 0, 0,   0,  -1};
    vt[6] = '{10, 144, 0, 0,   0,  -1};
    vt[7] = '{255,  0, 0, 0,   0,  -1};
    vt[8] = '{20,  10, 1, 1,  20,  -1};

    // Reset state
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_line_valid", line_valid, 0);
    chk("rst_line_addr", line_addr, 0);
    chk("rst_line_data", line_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_vcom", vcom, 0);
    cyc();
    rst = 0;

    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
`ifdef SHARP_FB_VCOM_EN
      if (vcom !== 1'((k / 4) % 2)) bad++;
`else
      if (vcom !== 1'b0) bad++;
`endif
      cyc();
    end
    chk("vcom_sequence", bad, 0);

    // Clean flush; commands re-issued mid-flush must be ignored
    line_ready = 1;
    run_op(0, 50);
    chk("clean_lines", got_addr.size(), 0);
    chk("clean_done_cycle", done_cyc, 168);
    chk("clean_busy_first", busy_first, 1);
    chk("clean_busy_after", busy_after, 0);
    chk("clean_done_count", done_cnt, 1);

    // Clear then flush all 168 lines
    run_op(1, 0);
    chk("clear_lines", got_addr.size(), 0);
    chk("clear_done_cycle", done_cyc, 168);
    chk("clear_done_count", done_cnt, 1);
    run_op(0, 0);
    chk("cflush_count", got_addr.size(), 168);
    bad = 0;
    for (int i = 0; i < got_addr.size(); i++)
      if (got_addr[i] !== 8'(i + 1) || got_data[i] !== ones_but(-1)) bad++;
    chk("cflush_addr_data", bad, 0);
    chk("cflush_done_cycle", done_cyc, 336);

    // Two pixels on one line, then a second refresh presents nothing
    wr(50, 0, 0);
    wr(50, 143, 0);
    run_op(0, 0);
    chk("l50_count", got_addr.size(), 1);
    if (got_addr.size() > 0) begin
      chk("l50_addr", got_addr[0], 50);
      chk("l50_data", got_data[0], ones_but(0) & ones_but(143));
    end
    run_op(0, 0);
    chk("l50_second_refresh", got_addr.size(), 0);
    wr(50, 0, 1);
    wr(50, 143, 1);
    run_op(0, 0);
    chk("l50_restore", got_addr.size(), 1);

    // Table of single writes
    foreach (vt[i]) begin
      wr(vt[i].l, vt[i].c, vt[i].p);
      run_op(0, 0);
      chk($sformatf("vec%0d_count", i), got_addr.size(), vt[i].hit ? 1 : 0);
      if (vt[i].hit && got_addr.size() > 0) begin
        chk($sformatf("vec%0d_addr", i), got_addr[0], vt[i].addr);
        chk($sformatf("vec%0d_data", i), got_data[0], ones_but(vt[i].zcol));
      end
      if (vt[i].hit && !vt[i].p) begin
        wr(vt[i].l, vt[i].c, 1);
        run_op(0, 0);
      end
    end

    // Stall on line 10, then write it during its handshake cycle
    line_ready = 0;
    wr(10, 3, 1);
    refresh = 1;
    cyc();
    refresh = 0;
    w = 0;
    while (!line_valid && w < 50) begin cyc(); w++; end
    chk("stall_latency", w, 10);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (line_valid !== 1'b1 || line_addr !== 8'd10 || line_data !== ones_but(-1)) bad++;
      cyc();
    end
    chk("stall_stable", bad, 0);
    line_ready = 1;
    wr_en = 1; wr_line = 8'd10; wr_col = 8'd7; wr_pixel = 0;
    @(negedge clk);
    chk("hs_valid", line_valid, 1);
    chk("hs_data_snapshot", line_data, ones_but(-1));
    cyc();
    wr_en = 0;
    chk("hs_valid_drop", line_valid, 0);
    w = 0;
    while (busy && w < 400) begin cyc(); w++; end
    if (busy) fail_now("stall_flush_end");
    run_op(0, 0);
    chk("race_count", got_addr.size(), 1);
    if (got_addr.size() > 0) begin
      chk("race_addr", got_addr[0], 10);
      chk("race_data", got_data[0], ones_but(7));
    end

    // Reset while a line is presented
    line_ready = 0;
    wr(30, 0, 0);
    refresh = 1;
    cyc();
    refresh = 0;
    w = 0;
    while (!line_valid && w < 50) begin cyc(); w++; end
    chk("rst_mid_present_seen", line_valid, 1);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("rst_mid_valid", line_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_addr", line_addr, 0);
    cyc();
    rst = 0;
    line_ready = 1;
    run_op(0, 0);
    chk("rst_dirty_cleared", got_addr.size(), 0);
    chk("rst_flush_done", done_cyc, 168);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
